apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB master port among NUM_REQ requesters.
- Accepts one request at a time, runs the APB SETUP/ACCESS phases, and waits for pready with a timeout.
- Returns read data and an error flag to the requester that was granted.
- Sits between internal command sources and the APB slave fabric on the pclk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles without pready before error response (>=2)

Ports:
pclk  input  1  APB clock; all logic on rising edge
preset_n  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester request valid; held until accepted
req_write_i  input  NUM_REQ  per-requester direction, 1=write
req_addr_i  input  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_wdata_i  input  NUM_REQ*DATA_W  packed write data, same packing
req_ready_o  output  NUM_REQ  one-hot accept; transfer occurs when valid&ready
rsp_valid_o  output  NUM_REQ  one-hot single-cycle completion pulse
rsp_rdata_o  output  DATA_W  response data, valid while rsp_valid_o is nonzero
rsp_err_o  output  1  response error, valid while rsp_valid_o is nonzero
grant_idx_o  output  $clog2(NUM_REQ)  index of current/last granted requester
psel_o  output  1  APB PSEL
penable_o  output  1  APB PENABLE
pwrite_o  output  1  APB PWRITE
paddr_o  output  ADDR_W  APB PADDR
pwdata_o  output  DATA_W  APB PWDATA
pready_i  input  1  APB PREADY
prdata_i  input  DATA_W  APB PRDATA
pslverr_i  input  1  APB PSLVERR

Behaviour:
- Reset values (async, immediate on preset_n low):
  - state=IDLE; all outputs 0, including psel_o and penable_o.
  - last_grant=NUM_REQ-1, so requester 0 has first priority; grant_idx_o=0.
  - Timeout counter 0.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. psel_o and penable_o decode from the registered state.
- IDLE:
  - Combinational search of req_valid_i starting at last_grant+1, wrapping modulo NUM_REQ.
  - The winner k gets req_ready_o[k]=1 in the same cycle; all other bits are 0. req_ready_o is 0 in every other state.
  - On the clock edge: latch req_write_i[k], address and wdata into pwrite_o/paddr_o/pwdata_o; grant_idx_o<=k; go to SETUP.
  - No valid: stay in IDLE; paddr_o/pwdata_o/pwrite_o hold their last values.
- SETUP: psel_o=1, penable_o=0. pready_i ignored. Unconditional move to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; counter increments each cycle pready_i=0.
  - pready_i=1: capture rsp_err<=pslverr_i; rsp_rdata<=prdata_i for reads, 0 for writes; go to RESP.
  - pready_i=0 on the TIMEOUT-th ACCESS cycle: rsp_err<=1, rsp_rdata<=0, go to RESP.
  - pready_i=1 on the TIMEOUT-th cycle is a normal completion; pready wins over timeout.
- RESP:
  - psel_o=0, penable_o=0; rsp_valid_o[grant_idx_o]=1 for exactly one cycle; rsp_rdata_o/rsp_err_o valid.
  - last_grant<=grant_idx_o; counter<=0; go to IDLE.
  - rsp_rdata_o/rsp_err_o hold until the next RESP.
- Latency: minimum 4 cycles from acceptance (IDLE) to rsp_valid pulse, plus one cycle per wait state. Back-to-back throughput is 1 transfer per 4+wait cycles.
- paddr_o, pwdata_o and pwrite_o are stable from SETUP through the end of ACCESS.
- Dropping req_valid_i before acceptance is legal and has no effect. Request inputs are ignored outside IDLE.
- Reset asserted mid-transfer: bus is released immediately, no rsp_valid pulse, in-flight request discarded, priority returns to requester 0.
- pslverr_i is sampled only with pready_i=1 in ACCESS.

Test Plan:
1. Write, no wait states: req 0 write addr 0x04 data 0x1234abcd, pready_i tied 1 -> sequence below; rsp_err_o=0.
   - Cycle 0: req_ready_o=0001.
   - Cycle 1: psel=1, penable=0, pwrite=1, paddr=0x04, pwdata=0x1234abcd.
   - Cycle 2: penable=1.
   - Cycle 3: rsp_valid_o=0001.
2. Read with 3 wait states: req 2 read addr 0x10; slave drives pready=1, prdata=0xDEADBEEF on the 4th ACCESS cycle -> penable high exactly 4 cycles; rsp_valid_o=0100; rsp_rdata_o=0xDEADBEEF; rsp_err_o=0.
3. Round-robin fairness: all 4 req_valid_i held high, pready=1, distinct addrs 0x00/0x01/0x02/0x03 -> paddr_o sequence 0x00,0x01,0x02,0x03,0x00; each grant 4 cycles apart.
4. Timeout: pready_i held 0 -> 16 ACCESS cycles, then rsp_err_o=1, rsp_rdata_o=0. Repeat with pready=1 and prdata=0x55 on the 16th ACCESS cycle -> rsp_err_o=0, rsp_rdata_o=0x55.
5. Slave error: read, pready=1 with pslverr=1 and prdata=0xA5A5A5A5 -> rsp_err_o=1, rsp_rdata_o=0xA5A5A5A5.
6. Reset mid-ACCESS: assert preset_n=0 during a wait state -> psel/penable drop without a clock edge; no rsp_valid pulse. After release, req 1 and req 3 valid -> req 1 granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master port
//
// Purpose: accepts one request at a time from NUM_REQ requesters using
// round-robin priority, runs the APB SETUP/ACCESS phases with a pready
// timeout, and returns read data and an error flag to the granted requester.
//
// Ports:
//   pclk, preset_n           clock, asynchronous active-low reset
//   req_valid_i/write/addr/wdata  per-requester request (packed per requester)
//   req_ready_o              one-hot accept, asserted only in IDLE
//   rsp_valid_o              one-hot single-cycle completion pulse
//   rsp_rdata_o, rsp_err_o   response payload, held until the next response
//   grant_idx_o              current/last granted requester
//   psel_o..pwdata_o         APB master request outputs
//   pready_i, prdata_i, pslverr_i  APB slave responses
module apb_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                        pclk,
   input  logic                        preset_n,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ-1:0]          req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [NUM_REQ-1:0]          rsp_valid_o,
   output logic [DATA_W-1:0]           rsp_rdata_o,
   output logic                        rsp_err_o,
   output logic [$clog2(NUM_REQ)-1:0]  grant_idx_o,
   output logic                        psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [ADDR_W-1:0]           paddr_o,
   output logic [DATA_W-1:0]           pwdata_o,
   input  logic                        pready_i,
   input  logic [DATA_W-1:0]           prdata_i,
   input  logic                        pslverr_i
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_grant_q, last_grant_d;
   logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic                found;
   logic [IDX_W-1:0]    win;
   logic [IDX_W-1:0]    cand;

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_idx_d  = grant_idx_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      cnt_d        = cnt_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      req_ready_o  = '0;
      rsp_valid_o  = '0;

      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready_o[win] = 1'b1;
               pwrite_d    = req_write_i[win];
               paddr_d     = req_addr_i[int'(win)*ADDR_W +: ADDR_W];
               pwdata_d    = req_wdata_i[int'(win)*DATA_W +: DATA_W];
               grant_idx_d = win;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // pready takes precedence over the timeout on the last cycle.
            if (pready_i) begin
               rsp_err_d   = pslverr_i;
               rsp_rdata_d = pwrite_q ? '0 : prdata_i;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = RESP;
               end
            end
         end
         RESP: begin
            rsp_valid_o[grant_idx_q] = 1'b1;
            last_grant_d = grant_idx_q;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         grant_idx_q  <= '0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         cnt_q        <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_idx_q  <= grant_idx_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         cnt_q        <= cnt_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable_o   = (state_q == ACCESS);
   assign pwrite_o    = pwrite_q;
   assign paddr_o     = paddr_q;
   assign pwdata_o    = pwdata_q;
   assign grant_idx_o = grant_idx_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard testbench for apb_req_arbiter
module tb_apb_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic                       pclk = 1'b0;
   logic                       preset_n;
   logic [NUM_REQ-1:0]         req_valid_i;
   logic [NUM_REQ-1:0]         req_write_i;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr_i;
   logic [NUM_REQ*DATA_W-1:0]  req_wdata_i;
   logic [NUM_REQ-1:0]         req_ready_o;
   logic [NUM_REQ-1:0]         rsp_valid_o;
   logic [DATA_W-1:0]          rsp_rdata_o;
   logic                       rsp_err_o;
   logic [1:0]                 grant_idx_o;
   logic                       psel_o;
   logic                       penable_o;
   logic                       pwrite_o;
   logic [ADDR_W-1:0]          paddr_o;
   logic [DATA_W-1:0]          pwdata_o;
   logic                       pready_i;
   logic [DATA_W-1:0]          prdata_i;
   logic                       pslverr_i;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   apb_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .pclk(pclk), .preset_n(preset_n),
      .req_valid_i(req_valid_i), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .grant_idx_o(grant_idx_o), .psel_o(psel_o), .penable_o(penable_o),
      .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
      .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int k, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata);
      req_write_i[k] = wr;
      req_addr_i[k*ADDR_W +: ADDR_W] = addr;
      req_wdata_i[k*DATA_W +: DATA_W] = wdata;
   endtask

   task automatic do_reset();
      @(negedge pclk);
      preset_n    = 1'b0;
      req_valid_i = '0;
      pready_i    = 1'b0;
      pslverr_i   = 1'b0;
      prdata_i    = '0;
      repeat (2) @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
   endtask

   // One complete transfer from requester k. waits >= TIMEOUT means the slave
   // never answers. extra adds other simultaneously valid requesters.
   task automatic run_xfer(input int k, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] prd, input logic serr,
                           input logic [3:0] extra, input string tag);
      exp_t e;
      exp_t got;
      int   acc;
      int   n_pen;
      logic [40:0] bus_exp;
      e.idx   = 2'(k);
      e.err   = (waits >= TIMEOUT) ? 1'b1 : serr;
      e.rdata = (waits >= TIMEOUT || wr) ? 32'h0 : prd;
      acc     = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
      bus_exp = {wr, addr, wdata};
      set_req(k, wr, addr, wdata);
      req_valid_i = extra | (4'b0001 << k);
      pready_i = 1'b0;
      #1;
      vectors++;
      if (req_ready_o !== (4'b0001 << k)) begin
         miscompares++;
         $display("FAIL %s req_ready: got %b exp %b", tag, req_ready_o, 4'b0001 << k);
      end
      sb.push_back(e);
      @(negedge pclk);
      vectors++;
      if ({psel_o, penable_o, req_ready_o} !== {2'b10, 4'b0000}) begin
         miscompares++;
         $display("FAIL %s setup psel/penable/ready: got %b%b %b exp 10 0000",
                  tag, psel_o, penable_o, req_ready_o);
      end
      vectors++;
      if ({pwrite_o, paddr_o, pwdata_o} !== bus_exp) begin
         miscompares++;
         $display("FAIL %s setup bus: got %h exp %h", tag,
                  {pwrite_o, paddr_o, pwdata_o}, bus_exp);
      end
      req_valid_i = '0;
      n_pen = 0;
      for (int n = 0; n < acc; n++) begin
         @(negedge pclk);
         if (psel_o === 1'b1 && penable_o === 1'b1 &&
             {pwrite_o, paddr_o, pwdata_o} === bus_exp) n_pen++;
         pready_i  = (waits < TIMEOUT) && (n == acc - 1);
         // Junk on prdata/pslverr while not ready: must not be captured.
         prdata_i  = pready_i ? prd : ~prd;
         pslverr_i = pready_i ? serr : 1'b1;
      end
      @(negedge pclk);
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      vectors++;
      if (n_pen !== acc) begin
         miscompares++;
         $display("FAIL %s access cycles: got %0d exp %0d", tag, n_pen, acc);
      end
      vectors++;
      if ({psel_o, penable_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL %s resp psel/penable: got %b%b exp 00", tag, psel_o, penable_o);
      end
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s scoreboard empty at response", tag);
      end else begin
         got = sb.pop_front();
         vectors++;
         if (rsp_valid_o !== (4'b0001 << got.idx)) begin
            miscompares++;
            $display("FAIL %s rsp_valid: got %b exp %b", tag, rsp_valid_o, 4'b0001 << got.idx);
         end
         vectors++;
         if ({rsp_rdata_o, rsp_err_o} !== {got.rdata, got.err}) begin
            miscompares++;
            $display("FAIL %s rsp rdata/err: got %h/%b exp %h/%b", tag,
                     rsp_rdata_o, rsp_err_o, got.rdata, got.err);
         end
         vectors++;
         if (grant_idx_o !== got.idx) begin
            miscompares++;
            $display("FAIL %s grant_idx: got %0d exp %0d", tag, grant_idx_o, got.idx);
         end
         @(negedge pclk);
         vectors++;
         if ({rsp_valid_o, rsp_rdata_o, rsp_err_o} !== {4'b0000, got.rdata, got.err}) begin
            miscompares++;
            $display("FAIL %s rsp hold: got %b %h/%b exp 0000 %h/%b", tag,
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, got.rdata, got.err);
         end
      end
   endtask

   task automatic test_reset();
      preset_n    = 1'b0;
      req_valid_i = '0;
      req_write_i = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      pready_i    = 1'b0;
      prdata_i    = '0;
      pslverr_i   = 1'b0;
      repeat (2) @(negedge pclk);
      vectors++;
      if ({psel_o, penable_o, req_ready_o, rsp_valid_o, rsp_err_o, grant_idx_o, pwrite_o} !== 13'b0 ||
          {paddr_o, pwdata_o, rsp_rdata_o} !== 72'b0) begin
         miscompares++;
         $display("FAIL reset outputs: got %b%b %b %b %b %0d %b %h %h %h exp all zero",
                  psel_o, penable_o, req_ready_o, rsp_valid_o, rsp_err_o, grant_idx_o,
                  pwrite_o, paddr_o, pwdata_o, rsp_rdata_o);
      end
      preset_n = 1'b1;
      @(negedge pclk);
   endtask

   task automatic test_write_nowait();
      run_xfer(0, 1'b1, 8'h04, 32'h1234abcd, 0, 32'h0, 1'b0, 4'b0000, "write_nowait");
   endtask

   task automatic test_read_wait();
      run_xfer(2, 1'b0, 8'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 4'b0000, "read_wait3");
   endtask

   task automatic test_round_robin();
      exp_t got;
      int   ns = 0;
      int   nr = 0;
      int   setup_cyc[5];
      logic [7:0] addr_seen[5];
      logic [7:0] addr_exp[5];
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_req(k, 1'b1, 8'(k), 32'h100 + 32'(k));
         addr_exp[k] = 8'(k);
      end
      addr_exp[4] = 8'h00;
      for (int i = 0; i < 5; i++) begin
         got.idx = 2'(i % 4); got.rdata = 32'h0; got.err = 1'b0;
         sb.push_back(got);
      end
      req_valid_i = 4'b1111;
      pready_i    = 1'b1;
      prdata_i    = 32'hFFFF_FFFF;
      for (int c = 0; c < 40 && nr < 5; c++) begin
         @(negedge pclk);
         if (psel_o === 1'b1 && penable_o === 1'b0 && ns < 5) begin
            setup_cyc[ns] = c;
            addr_seen[ns] = paddr_o;
            ns++;
         end
         if (rsp_valid_o !== 4'b0000) begin
            got = sb.pop_front();
            nr++;
            vectors++;
            if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {4'b0001 << got.idx, 1'b0, 32'h0}) begin
               miscompares++;
               $display("FAIL rr rsp %0d: got %b %b %h exp %b 0 0", nr, rsp_valid_o,
                        rsp_err_o, rsp_rdata_o, 4'b0001 << got.idx);
            end
         end
      end
      req_valid_i = '0;
      pready_i    = 1'b0;
      vectors++;
      if (ns !== 5 || nr !== 5) begin
         miscompares++;
         $display("FAIL rr counts: got %0d grants %0d rsps exp 5 5", ns, nr);
      end else begin
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if (addr_seen[i] !== addr_exp[i]) begin
               miscompares++;
               $display("FAIL rr paddr %0d: got %h exp %h", i, addr_seen[i], addr_exp[i]);
            end
            if (i > 0) begin
               vectors++;
               if (setup_cyc[i] - setup_cyc[i-1] !== 4) begin
                  miscompares++;
                  $display("FAIL rr spacing %0d: got %0d exp 4", i,
                           setup_cyc[i] - setup_cyc[i-1]);
               end
            end
         end
      end
      sb.delete();
      repeat (2) @(negedge pclk);
   endtask

   task automatic test_timeout();
      run_xfer(3, 1'b0, 8'h33, 32'h0, 99, 32'h77, 1'b0, 4'b0000, "timeout");
      run_xfer(3, 1'b0, 8'h34, 32'h0, TIMEOUT - 1, 32'h55, 1'b0, 4'b0000, "ready_on_last");
   endtask

   task automatic test_slave_error();
      run_xfer(1, 1'b0, 8'h20, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 4'b0000, "slverr");
   endtask

   task automatic test_reset_mid_access();
      int bad = 0;
      set_req(2, 1'b0, 8'h40, 32'h0);
      req_valid_i = 4'b0100;
      pready_i    = 1'b0;
      @(negedge pclk);
      req_valid_i = '0;
      repeat (2) @(negedge pclk);
      vectors++;
      if ({psel_o, penable_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL midrst pre: got psel/penable %b%b exp 11", psel_o, penable_o);
      end
      #2;
      preset_n = 1'b0;
      #1;
      vectors++;
      if ({psel_o, penable_o, rsp_valid_o} !== 6'b0) begin
         miscompares++;
         $display("FAIL midrst async: got %b%b %b exp 00 0000", psel_o, penable_o, rsp_valid_o);
      end
      repeat (3) begin
         @(negedge pclk);
         if (rsp_valid_o !== 4'b0000) bad++;
      end
      preset_n = 1'b1;
      @(negedge pclk);
      if (rsp_valid_o !== 4'b0000) bad++;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL midrst rsp_valid pulses: got %0d exp 0", bad);
      end
      set_req(3, 1'b1, 8'h66, 32'h6666);
      run_xfer(1, 1'b1, 8'h55, 32'h5555, 1, 32'h0, 1'b0, 4'b1000, "post_reset_prio");
   endtask

   initial begin
      test_reset();
      test_write_nowait();
      test_read_wait();
      test_round_robin();
      test_timeout();
      test_slave_error();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
